// File: rtl/motion_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : motion_sequencer
// Purpose  : Runs one SCARA move end to end. The pen is commanded and
//            confirmed first. The step-scale ratio is then computed with a
//            16-cycle restoring divider. Both steppers are started with a
//            single pulse, and completion is reported back to the
//            controller. Every value driven to the steppers and to the pen
//            comes from a flop, so these outputs are glitch-free.
//
// Ports    : clk, reset              - system clock, synchronous active-high reset
//            move_valid / move_ready - move request handshake (ready only in IDLE)
//            steps1/2, dir1/2        - joint step counts and directions
//            pen_req                 - pen state required for the move (1 = down)
//            pen_status              - pen state reported by the end effector
//            pen_set                 - pen command to the end effector
//            sm_new_in               - one-cycle start pulse to both steppers
//            sm_steps1/2, sm_dir1/2  - latched step counts and directions
//            scale1/2                - 8.8 fixed-point step scales
//            sm1/2_finished          - stepper done flags
//            move_done               - one-cycle move completion pulse
//            fault                   - sticky pen-timeout fault
//
// Options  : MOTION_SEQ_PEN_TIMEOUT_EN - when defined, a 26-bit counter
//            bounds the pen wait to PEN_TIMEOUT cycles and a timeout enters
//            the FAULT state. When undefined, the pen wait is unbounded
//            and fault is tied low.
//
// Revision : 1.0 - initial release
// ============================================================================
module motion_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned PEN_TIMEOUT   = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        move_valid,
  output logic        move_ready,
  input  logic [7:0]  steps1,
  input  logic [7:0]  steps2,
  input  logic        dir1,
  input  logic        dir2,
  input  logic        pen_req,
  input  logic        pen_status,
  output logic        pen_set,
  output logic        sm_new_in,
  output logic [7:0]  sm_steps1,
  output logic [7:0]  sm_steps2,
  output logic        sm_dir1,
  output logic        sm_dir2,
  output logic [15:0] scale1,
  output logic [15:0] scale2,
  input  logic        sm1_finished,
  input  logic        sm2_finished,
  output logic        move_done,
  output logic        fault
);

  // 1.0 in 8.8 fixed point: the joint that is not scaled steps at full rate.
  localparam logic [15:0] c_unity_scale = 16'h0100;

  // The settle counter only has to reach SETTLE_CYCLES-1.
  localparam int C_SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PEN    = 3'd1,
    S_SCALE  = 3'd2,
    S_ISSUE  = 3'd3,
    S_SETTLE = 3'd4,
    S_WAIT   = 3'd5,
    S_DONE   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  // The 26-bit pen counter can represent at most 2**26 cycles of waiting.
  if (PEN_TIMEOUT < 32'd1 || PEN_TIMEOUT > 32'd67108864) begin : g_pen_timeout_range
    $error("motion_sequencer: PEN_TIMEOUT must lie in 1..2**26");
  end

  // --------------------------------------------------------------------------
  // State and registers
  // --------------------------------------------------------------------------
  state_t                  state_q;

  // Move request captured at the handshake.
  logic [7:0]              req_steps1_q;
  logic [7:0]              req_steps2_q;
  logic                    req_dir1_q;
  logic                    req_dir2_q;
  logic                    req_pen_q;

  // Registered outputs.
  logic                    pen_set_q;
  logic                    sm_new_in_q;
  logic [7:0]              sm_steps1_q;
  logic [7:0]              sm_steps2_q;
  logic                    sm_dir1_q;
  logic                    sm_dir2_q;
  logic [15:0]             scale1_q;
  logic [15:0]             scale2_q;
  logic                    move_done_q;

  // Divider datapath. The dividend register shifts left by one bit per
  // cycle, and each new quotient bit enters at the bottom. After 16 cycles
  // the register holds the quotient.
  logic [7:0]              div_rem_q;
  logic [15:0]             div_dvd_q;
  logic [7:0]              div_dvs_q;
  logic [3:0]              div_cnt_q;
  logic                    max_is1_q;   // steps1 is the strictly larger count

  logic [C_SETTLE_W-1:0]   settle_cnt_q;

`ifdef MOTION_SEQ_PEN_TIMEOUT_EN
  logic [25:0]             pen_cnt_q;
  logic                    fault_q;
`endif

  // --------------------------------------------------------------------------
  // Max/min selection from the latched request. When the counts are equal,
  // steps2 is treated as the max joint.
  // --------------------------------------------------------------------------
  logic       steps1_gt_d;
  logic [7:0] max_steps_d;
  logic [7:0] min_steps_d;

  always_comb begin
    steps1_gt_d = (req_steps1_q > req_steps2_q);
    max_steps_d = steps1_gt_d ? req_steps1_q : req_steps2_q;
    min_steps_d = steps1_gt_d ? req_steps2_q : req_steps1_q;
  end

  // --------------------------------------------------------------------------
  // One restoring-division step. The partial remainder is always smaller
  // than the divisor. So after one more dividend bit is shifted in, it fits
  // in 9 bits, and the difference, when taken, fits back into 8 bits.
  // --------------------------------------------------------------------------
  logic [8:0]  div_trial_d;
  logic        div_ge_d;
  logic [7:0]  div_diff_d;
  logic [7:0]  div_rem_d;
  logic [15:0] div_dvd_d;

  always_comb begin
    div_trial_d = {div_rem_q, div_dvd_q[15]};
    div_ge_d    = (div_trial_d >= {1'b0, div_dvs_q});
    div_diff_d  = div_trial_d[7:0] - div_dvs_q;
    div_rem_d   = div_ge_d ? div_diff_d : div_trial_d[7:0];
    div_dvd_d   = {div_dvd_q[14:0], div_ge_d};
  end

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      req_steps1_q <= 8'd0;
      req_steps2_q <= 8'd0;
      req_dir1_q   <= 1'b0;
      req_dir2_q   <= 1'b0;
      req_pen_q    <= 1'b0;
      pen_set_q    <= 1'b0;
      sm_new_in_q  <= 1'b0;
      sm_steps1_q  <= 8'd0;
      sm_steps2_q  <= 8'd0;
      sm_dir1_q    <= 1'b0;
      sm_dir2_q    <= 1'b0;
      scale1_q     <= c_unity_scale;
      scale2_q     <= c_unity_scale;
      move_done_q  <= 1'b0;
      div_rem_q    <= 8'd0;
      div_dvd_q    <= 16'd0;
      div_dvs_q    <= 8'd0;
      div_cnt_q    <= 4'd0;
      max_is1_q    <= 1'b0;
      settle_cnt_q <= '0;
`ifdef MOTION_SEQ_PEN_TIMEOUT_EN
      pen_cnt_q    <= 26'd0;
      fault_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (move_valid) begin
            req_steps1_q <= steps1;
            req_steps2_q <= steps2;
            req_dir1_q   <= dir1;
            req_dir2_q   <= dir2;
            req_pen_q    <= pen_req;
            pen_set_q    <= pen_req;
`ifdef MOTION_SEQ_PEN_TIMEOUT_EN
            pen_cnt_q    <= 26'd0;
`endif
            state_q      <= S_PEN;
          end
        end

        S_PEN: begin
          if (pen_status == req_pen_q) begin
            // Preload the divider here, so the first quotient bit is
            // produced in the first SCALE cycle.
            div_rem_q <= 8'd0;
            div_dvd_q <= {max_steps_d, 8'h00};
            div_dvs_q <= min_steps_d;
            div_cnt_q <= 4'd0;
            max_is1_q <= steps1_gt_d;
            state_q   <= S_SCALE;
          end
`ifdef MOTION_SEQ_PEN_TIMEOUT_EN
          else if (32'(pen_cnt_q) + 32'd1 >= PEN_TIMEOUT) begin
            fault_q <= 1'b1;
            state_q <= S_FAULT;
          end else begin
            pen_cnt_q <= pen_cnt_q + 26'd1;
          end
`endif
        end

        S_SCALE: begin
          if (req_steps1_q == 8'd0 && req_steps2_q == 8'd0) begin
            // Nothing to move: finish without starting the steppers.
            move_done_q <= 1'b1;
            state_q     <= S_DONE;
          end else if (req_steps1_q == 8'd0 || req_steps2_q == 8'd0) begin
            scale1_q    <= c_unity_scale;
            scale2_q    <= c_unity_scale;
            sm_steps1_q <= req_steps1_q;
            sm_steps2_q <= req_steps2_q;
            sm_dir1_q   <= req_dir1_q;
            sm_dir2_q   <= req_dir2_q;
            sm_new_in_q <= 1'b1;
            state_q     <= S_ISSUE;
          end else begin
            div_rem_q <= div_rem_d;
            div_dvd_q <= div_dvd_d;
            div_cnt_q <= div_cnt_q + 4'd1;
            if (div_cnt_q == 4'd15) begin
              // The last quotient bit is taken straight from the step logic,
              // so the scales are valid together with the start pulse.
              scale1_q    <= max_is1_q ? div_dvd_d : c_unity_scale;
              scale2_q    <= max_is1_q ? c_unity_scale : div_dvd_d;
              sm_steps1_q <= req_steps1_q;
              sm_steps2_q <= req_steps2_q;
              sm_dir1_q   <= req_dir1_q;
              sm_dir2_q   <= req_dir2_q;
              sm_new_in_q <= 1'b1;
              state_q     <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          sm_new_in_q  <= 1'b0;
          settle_cnt_q <= '0;
          state_q      <= S_SETTLE;
        end

        S_SETTLE: begin
          // The steppers may still show the finished flags of the previous
          // move for a few cycles after the start pulse, so the flags are
          // not looked at yet.
          if (32'(settle_cnt_q) + 32'd1 >= SETTLE_CYCLES) begin
            state_q <= S_WAIT;
          end else begin
            settle_cnt_q <= settle_cnt_q + C_SETTLE_W'(1);
          end
        end

        S_WAIT: begin
          if (sm1_finished && sm2_finished) begin
            move_done_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end

        S_DONE: begin
          move_done_q <= 1'b0;
          state_q     <= S_IDLE;
        end

        S_FAULT: begin
          // Only reset leaves this state.
          state_q <= S_FAULT;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // move_ready is combinational with reset. It is therefore low while
  // reset is held, and high in the very first cycle after reset is released.
  assign move_ready = (state_q == S_IDLE) && !reset;
  assign pen_set    = pen_set_q;
  assign sm_new_in  = sm_new_in_q;
  assign sm_steps1  = sm_steps1_q;
  assign sm_steps2  = sm_steps2_q;
  assign sm_dir1    = sm_dir1_q;
  assign sm_dir2    = sm_dir2_q;
  assign scale1     = scale1_q;
  assign scale2     = scale2_q;
  assign move_done  = move_done_q;

`ifdef MOTION_SEQ_PEN_TIMEOUT_EN
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_motion_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_motion_sequencer
// Purpose  : Self-checking bench for motion_sequencer. Table-driven moves
//            feed a scoreboard that checks every stepper start pulse. Hand
//            sequences cover the zero-step/pen-delay move, reset during
//            WAIT and (with MOTION_SEQ_PEN_TIMEOUT_EN) the pen timeout.
// Revision : 1.0 - initial release
// ============================================================================
module tb_motion_sequencer;

  logic        clk;
  logic        reset;
  logic        move_valid;
  logic        move_ready;
  logic [7:0]  steps1, steps2;
  logic        dir1, dir2;
  logic        pen_req, pen_status, pen_set;
  logic        sm_new_in;
  logic [7:0]  sm_steps1, sm_steps2;
  logic        sm_dir1, sm_dir2;
  logic [15:0] scale1, scale2;
  logic        sm1_finished, sm2_finished;
  logic        move_done;
  logic        fault;

  motion_sequencer #(
    .SETTLE_CYCLES (4),
    .PEN_TIMEOUT   (20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .move_valid   (move_valid),
    .move_ready   (move_ready),
    .steps1       (steps1),
    .steps2       (steps2),
    .dir1         (dir1),
    .dir2         (dir2),
    .pen_req      (pen_req),
    .pen_status   (pen_status),
    .pen_set      (pen_set),
    .sm_new_in    (sm_new_in),
    .sm_steps1    (sm_steps1),
    .sm_steps2    (sm_steps2),
    .sm_dir1      (sm_dir1),
    .sm_dir2      (sm_dir2),
    .scale1       (scale1),
    .scale2       (scale2),
    .sm1_finished (sm1_finished),
    .sm2_finished (sm2_finished),
    .move_done    (move_done),
    .fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Move table record: inputs and expected scales / start-pulse latency.
  typedef struct {
    logic [7:0]  s1;
    logic [7:0]  s2;
    logic        d1;
    logic        d2;
    logic        pen;
    logic [15:0] sc1;
    logic [15:0] sc2;
    int          lat;
  } vec_t;

  // Scoreboard entry: what the next sm_new_in pulse must look like.
  typedef struct {
    int          t_exp;
    logic [15:0] sc1;
    logic [15:0] sc2;
    logic [7:0]  s1;
    logic [7:0]  s2;
    logic        d1;
    logic        d2;
  } exp_t;

  exp_t sb_q[$];
  int   n_issue  = 0;
  int   n_done   = 0;
  int   done_cyc = 0;

  task automatic push_exp(input int t_exp, input logic [15:0] sc1, input logic [15:0] sc2,
                          input logic [7:0] s1, input logic [7:0] s2, input logic d1, input logic d2);
    exp_t e;
    e.t_exp = t_exp; e.sc1 = sc1; e.sc2 = sc2;
    e.s1 = s1; e.s2 = s2; e.d1 = d1; e.d2 = d2;
    sb_q.push_back(e);
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset && sm_new_in) begin
      n_issue++;
      if (sb_q.size() == 0) begin
        check("unexpected_issue", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("issue_cycle", cyc, e.t_exp);
        check("scale1", {16'd0, scale1}, {16'd0, e.sc1});
        check("scale2", {16'd0, scale2}, {16'd0, e.sc2});
        check("sm_steps1", {24'd0, sm_steps1}, {24'd0, e.s1});
        check("sm_steps2", {24'd0, sm_steps2}, {24'd0, e.s2});
        check("sm_dir1", {31'd0, sm_dir1}, {31'd0, e.d1});
        check("sm_dir2", {31'd0, sm_dir2}, {31'd0, e.d2});
      end
    end
    if (!reset && move_done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  // One complete move: handshake, junk on the inputs while busy, drop the
  // finished flags after the start pulse, raise them later, expect one done.
  task automatic run_move(input vec_t v);
    int t_hs, i0, d0, waited, t_raise;
    @(negedge clk);
    i0 = n_issue;
    d0 = n_done;
    steps1 = v.s1; steps2 = v.s2; dir1 = v.d1; dir2 = v.d2;
    pen_req = v.pen; pen_status = v.pen;
    move_valid = 1'b1;
    check("ready_in_idle", {31'd0, move_ready}, 32'd1);
    t_hs = cyc;
    push_exp(t_hs + v.lat, v.sc1, v.sc2, v.s1, v.s2, v.d1, v.d2);
    @(negedge clk);
    // move_valid stays high with other values: the busy sequencer must ignore them.
    steps1 = ~v.s1; steps2 = v.s2 ^ 8'h5A; dir1 = ~v.d1; dir2 = ~v.d2; pen_req = ~v.pen;
    check("pen_set_t1", {31'd0, pen_set}, {31'd0, v.pen});
    check("busy_not_ready", {31'd0, move_ready}, 32'd0);
    repeat (4) @(negedge clk);
    move_valid = 1'b0;
    waited = 0;
    while (n_issue == i0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("issue_seen", n_issue - i0, 32'd1);
    sm1_finished = 1'b0;
    sm2_finished = 1'b0;
    repeat (8) @(negedge clk);
    check("no_early_done", n_done - d0, 32'd0);
    t_raise = cyc;
    sm1_finished = 1'b1;
    sm2_finished = 1'b1;
    waited = 0;
    while (n_done == d0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    repeat (2) @(negedge clk);
    check("done_count", n_done - d0, 32'd1);
    check("done_latency", done_cyc - t_raise, 32'd1);
  endtask

  vec_t vecs[9];

  initial begin
    int t_hs, i0, d0, waited;
    // steps1, steps2, dir1, dir2, pen, scale1, scale2, start-pulse latency
    vecs[0] = '{8'd200, 8'd50,  1'b1, 1'b0, 1'b0, 16'h0400, 16'h0100, 18};
    vecs[1] = '{8'd3,   8'd200, 1'b0, 1'b1, 1'b1, 16'h0100, 16'h42AA, 18};
    vecs[2] = '{8'd0,   8'd77,  1'b1, 1'b1, 1'b1, 16'h0100, 16'h0100, 3};
    vecs[3] = '{8'd100, 8'd100, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0100, 18};
    vecs[4] = '{8'd255, 8'd1,   1'b1, 1'b1, 1'b0, 16'hFF00, 16'h0100, 18};
    vecs[5] = '{8'd7,   8'd2,   1'b0, 1'b1, 1'b1, 16'h0380, 16'h0100, 18};
    vecs[6] = '{8'd5,   8'd0,   1'b1, 1'b0, 1'b0, 16'h0100, 16'h0100, 3};
    vecs[7] = '{8'd10,  8'd30,  1'b1, 1'b1, 1'b0, 16'h0100, 16'h0300, 18};
    vecs[8] = '{8'd250, 8'd3,   1'b0, 1'b0, 1'b0, 16'h5355, 16'h0100, 18};

    reset = 1'b1; move_valid = 1'b0;
    steps1 = 8'd0; steps2 = 8'd0; dir1 = 1'b0; dir2 = 1'b0;
    pen_req = 1'b0; pen_status = 1'b0;
    sm1_finished = 1'b1; sm2_finished = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("ready_in_reset", {31'd0, move_ready}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'd0, move_ready}, 32'd1);
    check("rst_scale1", {16'd0, scale1}, 32'h0100);
    check("rst_scale2", {16'd0, scale2}, 32'h0100);
    check("rst_pulses", {30'd0, sm_new_in, move_done}, 32'd0);
    check("rst_pen_fault", {30'd0, pen_set, fault}, 32'd0);
    check("rst_sm_steps", {16'd0, sm_steps1, sm_steps2}, 32'd0);

    // Table-driven moves
    for (int i = 0; i < 9; i++) run_move(vecs[i]);

    // Zero-step move, pen_req=1 with pen_status arriving 10 cycles later
    @(negedge clk);
    i0 = n_issue; d0 = n_done;
    steps1 = 8'd0; steps2 = 8'd0; pen_req = 1'b1; pen_status = 1'b0;
    move_valid = 1'b1;
    t_hs = cyc;
    @(negedge clk);
    move_valid = 1'b0;
    check("zero_pen_set_t1", {31'd0, pen_set}, 32'd1);
    repeat (9) @(negedge clk);
    check("zero_wait_pen", {31'd0, move_ready}, 32'd0);
    pen_status = 1'b1;
    waited = 0;
    while (n_done == d0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    repeat (2) @(negedge clk);
    check("zero_done_count", n_done - d0, 32'd1);
    check("zero_done_cycle", done_cyc - t_hs, 32'd12);
    check("zero_no_issue", n_issue - i0, 32'd0);

    // Reset asserted in WAIT
    @(negedge clk);
    i0 = n_issue; d0 = n_done;
    steps1 = 8'd200; steps2 = 8'd50; dir1 = 1'b0; dir2 = 1'b1;
    pen_req = 1'b1; pen_status = 1'b1;
    move_valid = 1'b1;
    t_hs = cyc;
    push_exp(t_hs + 18, 16'h0400, 16'h0100, 8'd200, 8'd50, 1'b0, 1'b1);
    @(negedge clk);
    move_valid = 1'b0;
    waited = 0;
    while (n_issue == i0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    sm1_finished = 1'b0; sm2_finished = 1'b0;
    waited = 0;
    while (cyc < t_hs + 26 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("wait_not_ready", {31'd0, move_ready}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("wrst_ready", {31'd0, move_ready}, 32'd1);
    check("wrst_pen_set", {31'd0, pen_set}, 32'd0);
    check("wrst_scales", {scale1, scale2}, 32'h0100_0100);
    check("wrst_sm_out", {14'd0, sm_dir1, sm_dir2, sm_steps1, sm_steps2}, 32'd0);
    check("wrst_pulses", {30'd0, sm_new_in, move_done}, 32'd0);
    sm1_finished = 1'b1; sm2_finished = 1'b1;
    repeat (8) @(negedge clk);
    check("wrst_no_stale_done", n_done - d0, 32'd0);

`ifdef MOTION_SEQ_PEN_TIMEOUT_EN
    // Pen never matches: FAULT after 20 PEN cycles, cleared by reset
    @(negedge clk);
    steps1 = 8'd9; steps2 = 8'd4; pen_req = 1'b0; pen_status = 1'b1;
    move_valid = 1'b1;
    @(negedge clk);
    move_valid = 1'b0;
    repeat (19) @(negedge clk);
    check("to_no_fault_yet", {31'd0, fault}, 32'd0);
    @(negedge clk);
    check("to_fault", {31'd0, fault}, 32'd1);
    check("to_not_ready", {31'd0, move_ready}, 32'd0);
    repeat (5) @(negedge clk);
    check("to_fault_sticky", {31'd0, fault}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("to_rst_fault", {31'd0, fault}, 32'd0);
    check("to_rst_ready", {31'd0, move_ready}, 32'd1);
`endif

    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
